hazard_controller: RTL

- Pipeline hazard and sequencing controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Generates PC/IF-ID/ID-EX/EX-MEM stall and flush controls.
- Generates EX-stage operand forwarding selects.
- Owns a small FSM that holds the pipeline while the multi-cycle mul/div unit is busy, with a cycle watchdog.
- Sits beside the ID/EX stages; consumes decoded register indices and EX/MEM/WB writeback info.

---
 rtl/rv_hazard_pkg.sv | 8 +
 rtl/hazard_controller_fwd.sv | 24 ++
 rtl/hazard_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rv_hazard_pkg.sv
// rv_hazard_pkg: shared FSM state and forwarding-select encodings for the hazard controller
package rv_hazard_pkg;
  typedef enum logic {RUN, MD_BUSY} hz_state_t;
  typedef logic [1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;
endpackage

// File: rtl/hazard_controller_fwd.sv
// forwarding_unit: EX-stage operand bypass selects (MEM over WB, x0 never forwards)
module forwarding_unit
  import rv_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);
  logic mem_ok, wb_ok;
  assign mem_ok = mem_reg_write && (mem_rd != '0);
  assign wb_ok  = wb_reg_write && (wb_rd != '0);
  // Youngest producer wins: MEM result before WB result before register file
  always_comb begin
    fwd_a = (mem_ok && mem_rd == ex_rs1) ? FWD_MEM : (wb_ok && wb_rd == ex_rs1) ? FWD_WB : FWD_RF;
    fwd_b = (mem_ok && mem_rd == ex_rs2) ? FWD_MEM : (wb_ok && wb_rd == ex_rs2) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencing, mul/div hold FSM with watchdog; HAZARD_PERF_CNT_EN adds perf counters
module hazard_controller
  import rv_hazard_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int MD_MAX_CYCLES = 64,
  parameter int MD_CNT_W      = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              ex_muldiv_start,
  input  logic              muldiv_done,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              imem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events,
`endif
  output logic              md_timeout
);
  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(MD_MAX_CYCLES - 1);

  hz_state_t           state, state_d;
  logic [MD_CNT_W-1:0] md_cnt, cnt_d;
  logic                timeout_d, lu, md_go, ex_rw_unused;

  // ex_reg_write is part of the EX bundle but only loads create stall hazards here
  assign ex_rw_unused = ex_reg_write;
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  assign md_go = ex_muldiv_start && !muldiv_done;

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd (
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // State, cycle counter and sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      md_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      state      <= state_d;
      md_cnt     <= cnt_d;
      md_timeout <= timeout_d;
    end
  end

  // Next state and stall/flush controls; mul/div hold outranks redirect, load-use and fetch wait
  always_comb begin
    state_d     = state;
    cnt_d       = md_cnt;
    timeout_d   = md_timeout;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_stall    = 1'b0;
    if (state == RUN) begin
      if (md_go) begin
        state_d     = MD_BUSY;
        cnt_d       = MD_CNT_W'(1);
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        ex_stall    = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end else if (muldiv_done) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (md_cnt == CNT_LAST) begin
      state_d   = RUN;
      cnt_d     = '0;
      timeout_d = 1'b1;
    end else begin
      cnt_d       = md_cnt + MD_CNT_W'(1);
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      ex_stall    = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Stall-cycle and flush-event counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      stall_cycles <= stall_cycles + {31'd0, pc_stall};
      flush_events <= flush_events + {31'd0, (if_id_flush || id_ex_flush)};
    end
  end
`endif
endmodule
